rate_phase_ctrl: RTL

//  Controller for the symbol-rate enable datapath: sequences start/stop of the divider,

---
 rtl/rate_phase_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rate_phase_ctrl.sv
// Symbol-rate enable controller.
// Sequences start/stop of the symbol divider, emits a one-cycle symbol strobe
// every NOS clocks, a gated TX strobe, and an RX sample strobe at a selectable
// phase. Switch configuration is sampled only at symbol boundaries so the
// TX/RX stages downstream never see a partial symbol.
module rate_phase_ctrl #(
  parameter int NOS   = 4,
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [3:0]       i_sw,
  output logic             o_sym_strb,
  output logic             o_tx_en,
  output logic             o_rx_strb,
  output logic [CNT_W-1:0] o_phase,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STOP = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NOS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             tx_run;
  logic             rx_run;
  logic [CNT_W-1:0] phase;
  logic             latch_en;
  logic             sym_nxt;
  logic             tx_nxt;
  logic             rx_nxt;
  logic             sw_any;
  logic             at_wrap;
  logic [CNT_W-1:0] sw_phase;

  assign sw_any   = |i_sw[1:0];
  assign at_wrap  = (count == CNT_LAST);
  assign sw_phase = CNT_W'(i_sw[3:2]);

  // State register; reset aborts any symbol in flight immediately.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: IDLE starts on any run switch, RUN/STOP only leave for IDLE
  // at a symbol boundary so the last symbol is always completed.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = sw_any ? S_RUN : S_IDLE;
      S_RUN: begin
        if (at_wrap) state_nxt = sw_any ? S_RUN : S_IDLE;
        else         state_nxt = sw_any ? S_RUN : S_STOP;
      end
      S_STOP: begin
        if (at_wrap) state_nxt = S_IDLE;
        else         state_nxt = sw_any ? S_RUN : S_STOP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath decode: counter advance, config latch and strobe values.
  // The count==phase compare uses the phase currently applied, so a new phase
  // latched at the boundary takes effect in the following symbol.
  always_comb begin
    count_nxt = '0;
    latch_en  = 1'b0;
    sym_nxt   = 1'b0;
    tx_nxt    = 1'b0;
    rx_nxt    = 1'b0;
    if (state != S_IDLE) begin
      count_nxt = count + CNT_W'(1);
      sym_nxt   = at_wrap;
      tx_nxt    = at_wrap & tx_run;
      rx_nxt    = rx_run & (count == phase);
    end
    latch_en = ((state == S_IDLE) && sw_any) || ((state == S_RUN) && at_wrap);
  end

  // Counter and latched configuration.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count  <= '0;
      tx_run <= 1'b0;
      rx_run <= 1'b0;
      phase  <= '0;
    end else begin
      count <= count_nxt;
      if (latch_en) begin
        tx_run <= i_sw[0];
        rx_run <= i_sw[1];
        phase  <= sw_phase;
      end
    end
  end

  // Registered strobes so every output comes straight from a flop.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_sym_strb <= 1'b0;
      o_tx_en    <= 1'b0;
      o_rx_strb  <= 1'b0;
    end else begin
      o_sym_strb <= sym_nxt;
      o_tx_en    <= tx_nxt;
      o_rx_strb  <= rx_nxt;
    end
  end

  assign o_phase = phase;
  assign o_state = state;

endmodule
